trigger_link_framer: RTL and testbench
======================================

# trigger_link_framer

Parametrised successor of the fixed four-link trigger output stage: packs NGROUPS groups of four 14-bit clusters into per-link 32-bit, 8b10b-ready frames for the GTX/GTP transmitters, at two words per bunch crossing on the 80 MHz user clock. It adds a configurable link-to-group map, BX0/overflow control characters, test-pattern modes, missing-load idle insertion and BX-alignment checking. It sits between the cluster sorter and the transceiver wrappers.

## Interface
- NLINKS, 4, number of output links (1..8)
- NGROUPS, 2, number of 4-cluster groups (1..8); NCLUSTERS = 4*NGROUPS
- LINK_MAP, 32'h0000_1010, 4 bits per link, link k carries group LINK_MAP[4k+3:4k]; values >= NGROUPS select idle payload
- clk_80  in  1  80 MHz user clock (TXUSRCLK2)
- reset_n  in  1  synchronous, active-low reset
- load_i  in  1  one-cycle strobe, clusters_i valid; nominally every 2nd cycle
- clusters_i  in  14*NCLUSTERS  cluster c at [14c+13:14c]
- ttc_bx0_i  in  1  BX0 flag, sampled with load_i
- overflow_i  in  1  cluster overflow, sampled with load_i
- mode_i  in  2  0 data, 1 PRBS-7, 2 idle, 3 counter
- inj_err_i  in  1  single-bit error injection request
- tx_data_o  out  32*NLINKS  link k word at [32k+31:32k]
- tx_isk_o  out  4*NLINKS  char-is-K per byte
- valid_clusters_o  out  NCLUSTERS  per-cluster valid, registered
- valid_or_o  out  1  OR of valid_clusters_o
- sync_err_o  out  1  sticky: load_i seen on phase 1
- ltncy_trig_o  out  1  one-cycle pulse when a latency-marker frame starts

## Operation
- Cluster c valid iff clusters_i[14c+10:14c+9] != 2'b11; IDLE_CLUSTER = 14'h0600.
- Phase bit alternates 0/1 each cycle. load_i forces phase to 0 on the next word (resync). load_i arriving when current phase is 1 sets sync_err_o (cleared only by reset).
- On load (phase 0): latch payload per link = {c3,c2,c1,c0} of mapped group (56 bits), ctrl byte, BX counter increments (7-bit, wraps 127->0).
- Phase 0 reached without load_i (missing load): frame sent with all four clusters IDLE_CLUSTER, ctrl K28.5; valid_clusters_o all 0.
- Ctrl byte priority: ttc_bx0_i -> K28.1 (8'h3C); else overflow_i -> K28.2 (8'h5C); else BX counter == 0 -> K28.3 (8'h7C, latency marker, pulses ltncy_trig_o); else K28.5 (8'hBC).
- Word0 = {payload[23:0], ctrl}, isk = 4'b0001. Word1 = payload[55:24], isk = 4'b0000.
- Modes replace payload only (ctrl unchanged): PRBS-7 (x^7+x^6+1, seed 7'h7F) advanced 56 bits per frame, same on all links; idle = 4 x IDLE_CLUSTER; counter = {8 copies of 7-bit frame counter}. mode_i sampled at frame start.
- inj_err_i pulse: bit 0 of the next word1 inverted on all links, once per pulse; pulses during pending injection merge.

## Timing
- Reset (reset_n low at clock edge): tx_data_o = {NLINKS{32'h0000_00BC}}, tx_isk_o = {NLINKS{4'b0001}}, valid_clusters_o = 0, valid_or_o = 0, sync_err_o = 0, ltncy_trig_o = 0, phase = 0, BX counter = 0, PRBS = 7'h7F.
- Reset mid-frame: partial word1 dropped; first post-reset word is the reset value.
- Latency: load_i at edge t -> word0 on tx at t+1, word1 at t+2; valid_clusters_o valid at t+1, valid_or_o same cycle (combinational OR of registers).
- Back-to-back loads every 2 cycles produce continuous frames; loads every cycle: each load restarts phase 0, word1 never sent, sync_err_o set.
- ttc_bx0_i and overflow_i simultaneous: K28.1 sent; overflow not signalled that frame.

## Test plan
- Reset: hold reset_n=0 3 cycles -> all links 32'h000000BC/isk 0001, outputs 0.
- Data: NLINKS=4, map {1,0,1,0}, group0 clusters 14'h0001..0004, load every 2 cycles -> link0 word0 = {payload[23:0],8'hBC}, word1 = payload[55:24] at t+1/t+2; link1 carries group1.
- BX0+overflow same load -> ctrl 8'h3C; next load with overflow only -> 8'h5C; every 128th frame 8'h7C and ltncy_trig_o pulse.
- Missing load: skip one load_i -> idle frame (clusters 14'h0600, ctrl BC), valid_or_o=0; load on odd phase -> sync_err_o=1 sticky.
- PRBS mode: 1000 frames, checker reconstructs PRBS-7 from 56-bit payloads with zero errors; single inj_err_i -> exactly one bit-0 error in word1.
- Invalid map entry (map value 15) -> link sends idle payload continuously.

Source files
------------

// File: rtl/trigger_link_framer_if.sv
// Sorter-to-transceiver bus of the trigger link framer: cluster load side and
// per-link 8b10b-ready word side, grouped so both ends share one definition.
interface trigger_link_framer_if #(
  parameter int NLINKS  = 4,
  parameter int NGROUPS = 2
);
  localparam int NCLUSTERS = 4 * NGROUPS;

  logic                      load_i;
  logic [14*NCLUSTERS-1:0]   clusters_i;
  logic                      ttc_bx0_i;
  logic                      overflow_i;
  logic [1:0]                mode_i;
  logic                      inj_err_i;

  logic [32*NLINKS-1:0]      tx_data_o;
  logic [4*NLINKS-1:0]       tx_isk_o;
  logic [NCLUSTERS-1:0]      valid_clusters_o;
  logic                      valid_or_o;
  logic                      sync_err_o;
  logic                      ltncy_trig_o;

  // Sorter / controlling side: supplies clusters and control, observes links.
  modport master (
    output load_i, clusters_i, ttc_bx0_i, overflow_i, mode_i, inj_err_i,
    input  tx_data_o, tx_isk_o, valid_clusters_o, valid_or_o, sync_err_o, ltncy_trig_o
  );

  // Framer side.
  modport slave (
    input  load_i, clusters_i, ttc_bx0_i, overflow_i, mode_i, inj_err_i,
    output tx_data_o, tx_isk_o, valid_clusters_o, valid_or_o, sync_err_o, ltncy_trig_o
  );
endinterface

// File: rtl/trigger_link_framer.sv
// trigger_link_framer: packs groups of four 14-bit clusters into two 32-bit
// words per bunch crossing per link (word0 carries a K-character ctrl byte),
// with link-to-group mapping, test-pattern modes, idle insertion on missing
// loads, BX-alignment checking and single-bit error injection.
module trigger_link_framer #(
  parameter int          NLINKS   = 4,
  parameter int          NGROUPS  = 2,
  parameter logic [31:0] LINK_MAP = 32'h0000_1010
) (
  input  logic                  clk_80,
  input  logic                  reset_n,
  trigger_link_framer_if.slave  bus
);
  localparam int NCLUSTERS = 4 * NGROUPS;

  localparam logic [13:0] IDLE_CLUSTER = 14'h0600;
  localparam logic [55:0] IDLE_PAYLOAD = {4{IDLE_CLUSTER}};

  localparam logic [7:0] K28_1 = 8'h3C;  // BX0
  localparam logic [7:0] K28_2 = 8'h5C;  // overflow
  localparam logic [7:0] K28_3 = 8'h7C;  // latency marker
  localparam logic [7:0] K28_5 = 8'hBC;  // plain comma

  localparam logic [1:0] MODE_DATA = 2'd0;
  localparam logic [1:0] MODE_PRBS = 2'd1;
  localparam logic [1:0] MODE_CNT  = 2'd3;

  // Phase = which word of the frame leaves at the next clock edge.
  localparam logic [0:0] PH_WORD0 = 1'b0;
  localparam logic [0:0] PH_WORD1 = 1'b1;

  logic [0:0]              phase_q, phase_d;
  logic [6:0]              bx_q, bx_d;
  logic [6:0]              prbs_q, prbs_d;
  logic                    inj_pend_q, inj_pend_d;
  logic [NLINKS-1:0][31:0] word1_q, word1_d;
  logic [32*NLINKS-1:0]    tx_data_q, tx_data_d;
  logic [4*NLINKS-1:0]     tx_isk_q, tx_isk_d;
  logic [NCLUSTERS-1:0]    valid_clusters_q, valid_clusters_d;
  logic                    sync_err_q, sync_err_d;
  logic                    ltncy_trig_q, ltncy_trig_d;

  logic [6:0]              bx_inc;
  logic [6:0]              prbs_walk;
  logic                    prbs_fb;
  logic [55:0]             prbs_bits;
  logic [NLINKS-1:0][55:0] payload;
  logic [3:0]              grp;
  logic [7:0]              ctrl;
  logic                    flip;

  // The BX counter advances on every load; the incremented value tags the frame.
  assign bx_inc = bx_q + 7'd1;

  // Next 56 bits of PRBS-7 (x^7+x^6+1); payload bit i is the i-th generated bit.
  always_comb begin
    // NOTE: every combinationally assigned variable gets a default first so no latch is inferred.
    prbs_walk = prbs_q;
    prbs_fb   = 1'b0;
    prbs_bits = '0;
    for (int i = 0; i < 56; i++) begin
      prbs_fb      = prbs_walk[6] ^ prbs_walk[5];
      prbs_bits[i] = prbs_fb;
      prbs_walk    = {prbs_walk[5:0], prbs_fb};
    end
  end

  // Per-link 56-bit payload of a loaded frame, selected by mode and link map.
  always_comb begin
    payload = '0;
    grp     = '0;
    for (int k = 0; k < NLINKS; k++) begin
      grp        = LINK_MAP[4*k +: 4];
      payload[k] = IDLE_PAYLOAD;
      case (bus.mode_i)
        MODE_DATA: begin
          // Unmapped group numbers fall through to the idle payload.
          for (int g = 0; g < NGROUPS; g++) begin
            if (grp == 4'(g)) payload[k] = bus.clusters_i[56*g +: 56];
          end
        end
        MODE_PRBS: payload[k] = prbs_bits;
        MODE_CNT:  payload[k] = {8{bx_inc}};
        default:   payload[k] = IDLE_PAYLOAD;
      endcase
    end
  end

  // Frame sequencing: start a loaded frame, insert an idle frame, or send word1.
  always_comb begin
    phase_d          = phase_q;
    bx_d             = bx_q;
    prbs_d           = prbs_q;
    inj_pend_d       = inj_pend_q | bus.inj_err_i;
    word1_d          = word1_q;
    tx_data_d        = tx_data_q;
    tx_isk_d         = tx_isk_q;
    valid_clusters_d = valid_clusters_q;
    sync_err_d       = sync_err_q;
    ltncy_trig_d     = 1'b0;
    ctrl             = K28_5;
    flip             = 1'b0;

    if (bus.load_i) begin
      // A load always restarts the frame; arriving on phase 1 means misalignment.
      bx_d = bx_inc;
      if (bus.ttc_bx0_i) begin
        ctrl = K28_1;
      end else if (bus.overflow_i) begin
        ctrl = K28_2;
      end else if (bx_inc == 7'd0) begin
        ctrl         = K28_3;
        ltncy_trig_d = 1'b1;
      end
      if (bus.mode_i == MODE_PRBS) prbs_d = prbs_walk;
      for (int c = 0; c < NCLUSTERS; c++) begin
        valid_clusters_d[c] = (bus.clusters_i[14*c+9 +: 2] != 2'b11);
      end
      sync_err_d = sync_err_q | (phase_q == PH_WORD1);
      phase_d    = PH_WORD1;
      for (int k = 0; k < NLINKS; k++) begin
        tx_data_d[32*k +: 32] = {payload[k][23:0], ctrl};
        tx_isk_d[4*k +: 4]    = 4'b0001;
        word1_d[k]            = payload[k][55:24];
      end
    end else if (phase_q == PH_WORD0) begin
      // Missing load: idle frame keeps the link framed; counters do not advance.
      valid_clusters_d = '0;
      phase_d          = PH_WORD1;
      for (int k = 0; k < NLINKS; k++) begin
        tx_data_d[32*k +: 32] = {IDLE_PAYLOAD[23:0], K28_5};
        tx_isk_d[4*k +: 4]    = 4'b0001;
        word1_d[k]            = IDLE_PAYLOAD[55:24];
      end
    end else begin
      // Word1: any pending (or same-cycle) injection request flips bit 0 once.
      flip       = inj_pend_q | bus.inj_err_i;
      inj_pend_d = 1'b0;
      phase_d    = PH_WORD0;
      for (int k = 0; k < NLINKS; k++) begin
        tx_data_d[32*k +: 32] = word1_q[k] ^ {31'b0, flip};
        tx_isk_d[4*k +: 4]    = 4'b0000;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_80) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!reset_n) begin
      // NOTE: the word1 staging registers are reset too, dropping any half-sent frame.
      phase_q          <= PH_WORD0;
      bx_q             <= 7'd0;
      prbs_q           <= 7'h7F;
      inj_pend_q       <= 1'b0;
      word1_q          <= '0;
      tx_data_q        <= {NLINKS{32'h0000_00BC}};
      tx_isk_q         <= {NLINKS{4'b0001}};
      valid_clusters_q <= '0;
      sync_err_q       <= 1'b0;
      ltncy_trig_q     <= 1'b0;
    end else begin
      phase_q          <= phase_d;
      bx_q             <= bx_d;
      prbs_q           <= prbs_d;
      inj_pend_q       <= inj_pend_d;
      word1_q          <= word1_d;
      tx_data_q        <= tx_data_d;
      tx_isk_q         <= tx_isk_d;
      valid_clusters_q <= valid_clusters_d;
      sync_err_q       <= sync_err_d;
      ltncy_trig_q     <= ltncy_trig_d;
    end
  end

  assign bus.tx_data_o        = tx_data_q;
  assign bus.tx_isk_o         = tx_isk_q;
  assign bus.valid_clusters_o = valid_clusters_q;
  assign bus.valid_or_o       = |valid_clusters_q;
  assign bus.sync_err_o       = sync_err_q;
  assign bus.ltncy_trig_o     = ltncy_trig_q;
endmodule

// File: tb/tb_trigger_link_framer.sv
// Self-checking bench for trigger_link_framer: randomized loads, modes, control
// flags, skipped/odd loads and resets, compared against a frame-level model.
module tb_trigger_link_framer;
  localparam int          NLINKS  = 4;
  localparam int          NGROUPS = 2;
  localparam int          NCL     = 4 * NGROUPS;
  // link0 -> group0, link1 -> group1, link2 -> group0, link3 -> 15 (unmapped)
  localparam logic [31:0] MAP     = 32'h0000_F010;
  localparam logic [13:0] IDLE_CL = 14'h0600;

  logic clk_80  = 1'b0;
  logic reset_n = 1'b0;
  always #6 clk_80 = ~clk_80;

  trigger_link_framer_if #(.NLINKS(NLINKS), .NGROUPS(NGROUPS)) bus ();

  trigger_link_framer #(
    .NLINKS  (NLINKS),
    .NGROUPS (NGROUPS),
    .LINK_MAP(MAP)
  ) dut (
    .clk_80 (clk_80),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int              m_phase;     // 0: next word opens a frame, 1: next word is word1
  int              m_bx;        // BX counter, 0..127
  bit              m_hist[$];   // last 7 PRBS bits, oldest first
  bit              m_pend;
  bit              m_sync;
  logic [31:0]     m_word1 [NLINKS];
  logic [NCL-1:0]  m_valid;
  logic [127:0]    e_data;
  logic [15:0]     e_isk;
  bit              e_ltncy;
  logic [31:0]     map_v;

  task automatic model_reset();
    m_phase = 0;
    m_bx    = 0;
    m_hist.delete();
    repeat (7) m_hist.push_back(1'b1);
    m_pend  = 1'b0;
    m_sync  = 1'b0;
    m_valid = '0;
    for (int k = 0; k < NLINKS; k++) m_word1[k] = '0;
    e_data  = {NLINKS{32'h0000_00BC}};
    e_isk   = {NLINKS{4'b0001}};
    e_ltncy = 1'b0;
  endtask

  function automatic logic [55:0] group_payload(input int grp, input logic [14*NCL-1:0] cl);
    logic [55:0] p;
    p = {4{IDLE_CL}};
    if (grp < NGROUPS)
      for (int j = 0; j < 4; j++) p[14*j +: 14] = cl[14*(4*grp+j) +: 14];
    return p;
  endfunction

  // Sequence recurrence of x^7+x^6+1: b[n] = b[n-7] ^ b[n-6].
  task automatic prbs56(output logic [55:0] pr);
    bit b;
    pr = '0;
    for (int i = 0; i < 56; i++) begin
      b = m_hist[0] ^ m_hist[1];
      pr[i] = b;
      m_hist.push_back(b);
      void'(m_hist.pop_front());
    end
  endtask

  task automatic model_step(input bit rst, input bit ld, input logic [14*NCL-1:0] cl,
                            input bit bx0, input bit ovf, input logic [1:0] md, input bit inj);
    logic [55:0] pay [NLINKS];
    logic [55:0] pr;
    logic [7:0]  ctrl;
    bit          fl;
    e_ltncy = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (ld || m_phase == 0) begin
      ctrl = 8'hBC;
      for (int k = 0; k < NLINKS; k++) pay[k] = {4{IDLE_CL}};
      if (ld) begin
        if (m_phase == 1) m_sync = 1'b1;
        m_bx = (m_bx + 1) % 128;
        if (bx0)           ctrl = 8'h3C;
        else if (ovf)      ctrl = 8'h5C;
        else if (m_bx == 0) begin ctrl = 8'h7C; e_ltncy = 1'b1; end
        pr = '0;
        if (md == 2'd1) prbs56(pr);
        for (int k = 0; k < NLINKS; k++) begin
          case (md)
            2'd0: pay[k] = group_payload(int'(map_v[4*k +: 4]), cl);
            2'd1: pay[k] = pr;
            2'd2: pay[k] = {4{IDLE_CL}};
            default: for (int j = 0; j < 8; j++) pay[k][7*j +: 7] = 7'(m_bx);
          endcase
        end
        for (int c = 0; c < NCL; c++) m_valid[c] = (cl[14*c+9 +: 2] != 2'b11);
      end else begin
        m_valid = '0;
      end
      m_pend = m_pend | inj;
      for (int k = 0; k < NLINKS; k++) begin
        e_data[32*k +: 32] = {pay[k][23:0], ctrl};
        e_isk[4*k +: 4]    = 4'b0001;
        m_word1[k]         = pay[k][55:24];
      end
      m_phase = 1;
    end else begin
      fl     = m_pend | inj;
      m_pend = 1'b0;
      for (int k = 0; k < NLINKS; k++) begin
        e_data[32*k +: 32] = m_word1[k] ^ {31'b0, fl};
        e_isk[4*k +: 4]    = 4'b0000;
      end
      m_phase = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [14*NCL-1:0] rand_clusters();
    logic [14*NCL-1:0] cl;
    for (int c = 0; c < NCL; c++) cl[14*c +: 14] = 14'($urandom);
    if ($urandom_range(0, 7) == 0)
      for (int c = 0; c < NCL; c++) cl[14*c+9 +: 2] = 2'b11;
    return cl;
  endfunction

  // One clock: drive at negedge, predict, compare #1 after the rising edge.
  task automatic step(input bit rst, input bit ld, input logic [14*NCL-1:0] cl,
                      input bit bx0, input bit ovf, input logic [1:0] md, input bit inj);
    @(negedge clk_80);
    reset_n        = !rst;
    bus.load_i     = ld;
    bus.clusters_i = cl;
    bus.ttc_bx0_i  = bx0;
    bus.overflow_i = ovf;
    bus.mode_i     = md;
    bus.inj_err_i  = inj;
    model_step(rst, ld, cl, bx0, ovf, md, inj);
    @(posedge clk_80);
    #1;
    check("tx_data",        128'(bus.tx_data_o),        128'(e_data));
    check("tx_isk",         128'(bus.tx_isk_o),         128'(e_isk));
    check("valid_clusters", 128'(bus.valid_clusters_o), 128'(m_valid));
    check("valid_or",       128'(bus.valid_or_o),       128'(|m_valid));
    check("sync_err",       128'(bus.sync_err_o),       128'(m_sync));
    check("ltncy_trig",     128'(bus.ltncy_trig_o),     128'(e_ltncy));
  endtask

  // Load followed by one idle cycle (word1).
  task automatic frame(input logic [14*NCL-1:0] cl, input bit bx0, input bit ovf,
                       input logic [1:0] md, input bit inj);
    step(1'b0, 1'b1, cl, bx0, ovf, md, inj);
    step(1'b0, 1'b0, rand_clusters(), 1'b0, 1'b0, md, 1'b0);
  endtask

  logic [14*NCL-1:0] dir_cl;

  initial begin
    map_v          = MAP;
    bus.load_i     = 1'b0;
    bus.clusters_i = '0;
    bus.ttc_bx0_i  = 1'b0;
    bus.overflow_i = 1'b0;
    bus.mode_i     = 2'd0;
    bus.inj_err_i  = 1'b0;
    model_reset();

    // Reset held for three cycles.
    repeat (3) step(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Directed data frame: group0 = 1..4, group1 = 5..8.
    for (int c = 0; c < NCL; c++) dir_cl[14*c +: 14] = 14'(c + 1);
    frame(dir_cl, 1'b0, 1'b0, 2'd0, 1'b0);
    // BX0 with overflow, then overflow only.
    frame(rand_clusters(), 1'b1, 1'b1, 2'd0, 1'b0);
    frame(rand_clusters(), 1'b0, 1'b1, 2'd0, 1'b0);

    // Continuous data frames across two BX-counter wraps; flags kept off at the marker.
    for (int n = 0; n < 300; n++) begin
      bit q;
      q = (m_bx != 127);
      frame(rand_clusters(), q && ($urandom_range(0, 15) == 0),
            q && ($urandom_range(0, 7) == 0), 2'd0, 1'b0);
    end

    // Missing load, then a load on the odd phase, then loads every cycle.
    step(1'b0, 1'b0, rand_clusters(), 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, rand_clusters(), 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b1, rand_clusters(), 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (6) step(1'b0, 1'b1, rand_clusters(), 1'b0, 1'b0, 2'd0, 1'b0);
    frame(rand_clusters(), 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset in the middle of a frame drops word1.
    step(1'b0, 1'b1, rand_clusters(), 1'b0, 1'b0, 2'd3, 1'b0);
    step(1'b1, 1'b0, rand_clusters(), 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b0, rand_clusters(), 1'b0, 1'b0, 2'd0, 1'b0);

    // Mixed traffic: all modes, skipped and odd loads, injections, rare resets.
    for (int n = 0; n < 800; n++) begin
      bit ld;
      if (m_phase == 0) ld = ($urandom_range(0, 7) != 0);
      else              ld = ($urandom_range(0, 11) == 0);
      step($urandom_range(0, 249) == 0, ld, rand_clusters(),
           $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
           2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
    end

    // PRBS run from reset: 1000 frames with a single injection.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int n = 0; n < 1000; n++) frame(rand_clusters(), 1'b0, 1'b0, 2'd1, n == 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
